// File: rtl/ex_type_i.sv
// rtl/ex_type_i.sv - OP-IMM execute stage with iterative 1-bit-per-cycle shifter
module ex_type_i #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               flush_i,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic               reg_we_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    output logic               valid_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [XLEN-1:0]    reg_wdata_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam int         SHAMT_W    = 5;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        K_SLL,
        K_SRL,
        K_SRA
    } kind_t;

    state_t               r_state;
    kind_t                r_kind;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [XLEN-1:0]      r_sh_data;
    logic                 r_sh_we;
    logic [RADDR_W-1:0]   r_sh_waddr;
    logic                 r_valid;
    logic                 r_we;
    logic [RADDR_W-1:0]   r_waddr;
    logic [XLEN-1:0]      r_wdata;

    logic                 w_is_opimm;
    logic [2:0]           w_funct3;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_is_shift;
    kind_t                w_kind;
    logic                 w_we;
    logic                 w_accept;
    logic [XLEN-1:0]      w_alu_result;
    logic [XLEN-1:0]      w_shift_next;
    logic                 w_unused_bits;

    assign ready_o     = (r_state == S_IDLE);
    assign valid_o     = r_valid;
    assign reg_we_o    = r_we;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;

    assign w_is_opimm = (inst_i[6:0] == OPC_OP_IMM);
    assign w_funct3   = inst_i[14:12];
    assign w_shamt    = op2_i[SHAMT_W-1:0];
    assign w_is_shift = w_is_opimm && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));
    assign w_kind     = (w_funct3 == 3'b001) ? K_SLL : (inst_i[30] ? K_SRA : K_SRL);
    assign w_we       = reg_we_i && (reg_waddr_i != '0);
    assign w_accept   = valid_i && ready_o && !flush_i;

    assign w_unused_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7], op2_i[XLEN-1:SHAMT_W]};

    // Shift encodings fall to the default: only reached here when shamt is zero.
    always_comb begin
        w_alu_result = op1_i;
        case (w_funct3)
            3'b000:  w_alu_result = op1_i + op2_i;
            3'b010:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
            3'b011:  w_alu_result = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
            3'b100:  w_alu_result = op1_i ^ op2_i;
            3'b110:  w_alu_result = op1_i | op2_i;
            3'b111:  w_alu_result = op1_i & op2_i;
            default: w_alu_result = op1_i;
        endcase
    end

    always_comb begin
        w_shift_next = r_sh_data;
        case (r_kind)
            K_SLL:   w_shift_next = {r_sh_data[XLEN-2:0], 1'b0};
            K_SRL:   w_shift_next = {1'b0, r_sh_data[XLEN-1:1]};
            K_SRA:   w_shift_next = {r_sh_data[XLEN-1], r_sh_data[XLEN-1:1]};
            default: w_shift_next = r_sh_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_kind     <= K_SLL;
            r_cnt      <= '0;
            r_sh_data  <= '0;
            r_sh_we    <= 1'b0;
            r_sh_waddr <= '0;
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_opimm) begin
                            r_valid <= 1'b1;
                            r_we    <= 1'b0;
                            r_waddr <= reg_waddr_i;
                            r_wdata <= '0;
                        end else if (w_is_shift && (w_shamt != '0)) begin
                            r_state    <= S_SHIFT;
                            r_kind     <= w_kind;
                            r_cnt      <= w_shamt;
                            r_sh_data  <= op1_i;
                            r_sh_we    <= w_we;
                            r_sh_waddr <= reg_waddr_i;
                        end else begin
                            r_valid <= 1'b1;
                            r_we    <= w_we;
                            r_waddr <= reg_waddr_i;
                            r_wdata <= w_alu_result;
                        end
                    end
                end
                S_SHIFT: begin
                    // Flush wins over completion: the shift is dropped with no result.
                    if (flush_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_sh_data <= w_shift_next;
                        r_cnt     <= r_cnt - 1'b1;
                        if (r_cnt == SHAMT_W'(1)) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b1;
                            r_we    <= r_sh_we;
                            r_waddr <= r_sh_waddr;
                            r_wdata <= w_shift_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
